boot_mem_loader: RTL and testbench

- Upstream feeder for the CPU test top's external data-memory write path: Ext_MemWrite, Ext_WriteData, Ext_DataAdr, plus the CPU reset that gates them.
- Takes a byte stream (from a UART RX or bench driver) and holds the CPU in reset.
- Assembles little-endian 32-bit words and writes them to consecutive data-memory addresses.
- Releases the CPU once the image is loaded. Erroneous images leave the CPU held in reset.

---
 rtl/boot_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_boot_mem_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_mem_loader.sv
// Boot loader: turns a byte stream into little-endian word writes on the CPU data-memory port
// and holds the CPU in reset until the image is complete. Optional XOR trailer: LOADER_CHECKSUM_EN.
module boot_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        reload,
    output logic        cpu_reset,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  o_dbg_state
);
    // rx_valid/rx_data form a valid-only stream: a byte is consumed in every cycle rx_valid is
    // high, there is no ready, and the producer may leave gaps of any length between bytes.

    localparam int IW = $clog2(MAX_WORDS + 1);

    localparam logic [2:0] S_HDR_LO = 3'd0;
    localparam logic [2:0] S_HDR_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd3;
    localparam logic [2:0] S_LOADED = S_CHK;
`else
    localparam logic [2:0] S_LOADED = S_RUN;
`endif

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [15:0]   r_count;
    logic [15:0]   w_hdr_count;
    logic [IW-1:0] r_index;
    logic [1:0]    r_lane;
    logic [23:0]   r_asm;
    logic          r_wr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_adr;

    assign w_hdr_count   = {rx_data, r_count[7:0]};
    assign Ext_MemWrite  = r_wr;
    assign Ext_WriteData = r_wdata;
    assign Ext_DataAdr   = r_adr;
    assign o_dbg_state   = r_state;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       w_accept_last;

    // Leave DATA as soon as the last payload byte lands so a back-to-back CHK byte is caught.
    assign w_accept_last = (r_state == S_DATA) && rx_valid && (r_lane == 2'd3) &&
                           (32'(r_index) + 32'd1 == 32'(r_count));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xor <= 8'h00;
        end else if (r_state == S_RUN && reload) begin
            r_xor <= 8'h00;
        end else if (r_state == S_DATA && rx_valid) begin
            r_xor <= r_xor ^ rx_data;
        end
    end
`else
    logic w_final_write;

    // Stay in DATA through the final strobe so cpu_reset is still high while it lands.
    assign w_final_write = r_wr && (32'(r_index) == 32'(r_count));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HDR_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HDR_LO: begin
                if (rx_valid) w_next_state = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (rx_valid) begin
                    if (32'(w_hdr_count) > 32'(MAX_WORDS)) begin
                        w_next_state = S_ERR;
                    end else if (w_hdr_count == 16'd0) begin
                        w_next_state = S_LOADED;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_accept_last) w_next_state = S_CHK;
`else
                if (w_final_write) w_next_state = S_RUN;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) w_next_state = (rx_data == r_xor) ? S_RUN : S_ERR;
            end
`endif
            S_RUN: begin
                if (reload) w_next_state = S_HDR_LO;
            end
            default: w_next_state = r_state;
        endcase
    end

    always_comb begin
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            S_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERR:   error = 1'b1;
            default: busy  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 16'd0;
            r_index <= '0;
            r_lane  <= 2'd0;
            r_asm   <= 24'd0;
            r_wr    <= 1'b0;
            r_wdata <= 32'd0;
            r_adr   <= BASE_ADDR;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_HDR_LO: begin
                    if (rx_valid) r_count[7:0] <= rx_data;
                end
                S_HDR_HI: begin
                    if (rx_valid) r_count[15:8] <= rx_data;
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_asm[7:0]   <= rx_data;
                            2'd1: r_asm[15:8]  <= rx_data;
                            2'd2: r_asm[23:16] <= rx_data;
                            default: begin
                                // Lane 3 bypasses the assembly register straight into the write word.
                                r_wr    <= 1'b1;
                                r_wdata <= {rx_data, r_asm};
                                r_adr   <= BASE_ADDR + (32'(r_index) << 2);
                                r_index <= r_index + IW'(1);
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        r_index <= '0;
                        r_lane  <= 2'd0;
                        r_adr   <= BASE_ADDR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_mem_loader.sv
// Bench for boot_mem_loader: directed and randomized images scored against a stream-level model
// of the expected memory writes and final loader status.
module tb_boot_mem_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          MAX_W = 64;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        reload;
    logic        cpu_reset;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  img_q[$];
    logic [31:0] words_q[$];

    boot_mem_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAX_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .reload       (reload),
        .cpu_reset    (cpu_reset),
        .Ext_MemWrite (Ext_MemWrite),
        .Ext_WriteData(Ext_WriteData),
        .Ext_DataAdr  (Ext_DataAdr),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .o_dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1);
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge. comp = this edge completes a word.
    task automatic tick(input bit comp);
        logic [63:0] e;
        @(posedge clk);
        #1;
        chk1("strobe", Ext_MemWrite, comp);
        if (Ext_MemWrite === 1'b1) chk1("strobe_while_cpu_run", cpu_reset, 1'b1);
        if (comp && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk32("wr_addr", Ext_DataAdr, e[63:32]);
            chk32("wr_data", Ext_WriteData, e[31:0]);
        end
    endtask

    task automatic expect_status(input string tag, input bit run, input bit err);
        chk1({tag, "_cpu_reset"}, cpu_reset, !run);
        chk1({tag, "_done"}, done, run);
        chk1({tag, "_error"}, error, err);
        chk1({tag, "_busy"}, busy, !(run || err));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick(1'b0);
        reload = 1'b0;
    endtask

    task automatic build_image(input int cnt);
        logic [7:0] x;
        x = 8'h00;
        img_q.delete();
        img_q.push_back(cnt[7:0]);
        img_q.push_back(cnt[15:8]);
        foreach (words_q[k]) begin
            for (int b = 0; b < 4; b++) begin
                img_q.push_back(words_q[k][8*b +: 8]);
                x = x ^ words_q[k][8*b +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        img_q.push_back(x);
`endif
    endtask

    // Model: header gives count; payload byte p completes word p/4 when p%4==3 and p/4 < count.
    task automatic run_image(input int gap_max, input bit gap_reload);
        int cnt;
        bit bad;
        cnt = int'({img_q[1], img_q[0]});
        bad = cnt > MAX_W;
        for (int i = 0; i < img_q.size(); i++) begin
            bit comp;
            int p;
            p    = i - 2;
            comp = !bad && p >= 0 && (p % 4) == 3 && (p / 4) < cnt;
            if (comp) begin
                exp_q.push_back({BASE + 32'(4 * (p / 4)), img_q[i], img_q[i-1], img_q[i-2], img_q[i-3]});
            end
            repeat ($urandom_range(gap_max, 0)) begin
                if (gap_reload) reload = ($urandom_range(3, 0) == 0);
                tick(1'b0);
                reload = 1'b0;
            end
            rx_valid = 1'b1;
            rx_data  = img_q[i];
            tick(comp);
            rx_valid = 1'b0;
        end
        chk32("exp_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        do_reset();

        chk1("rst_cpu_reset", cpu_reset, 1'b1);
        chk1("rst_memwrite", Ext_MemWrite, 1'b0);
        chk32("rst_wdata", Ext_WriteData, 32'd0);
        chk32("rst_adr", Ext_DataAdr, BASE);
        expect_status("rst", 1'b0, 1'b0);

        // Two-word directed image, back-to-back bytes.
        words_q = '{32'h12345678, 32'hDEADBEEF};
        build_image(2);
        run_image(0, 1'b0);
`ifndef LOADER_CHECKSUM_EN
        chk1("cpu_reset_on_final_write", cpu_reset, 1'b1);
`endif
        tick(1'b0);
        expect_status("img2", 1'b1, 1'b0);
        chk32("hold_adr", Ext_DataAdr, BASE + 32'd4);
        chk32("hold_data", Ext_WriteData, 32'hDEADBEEF);

        // Bytes in RUN are ignored.
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick(1'b0);
        end
        rx_valid = 1'b0;
        expect_status("run_ignore", 1'b1, 1'b0);

        // Reload and a one-word image.
        pulse_reload();
        expect_status("reload", 1'b0, 1'b0);
        chk32("reload_adr", Ext_DataAdr, BASE);
        words_q = '{32'hDDCCBBAA};
        build_image(1);
        run_image(0, 1'b0);
        tick(1'b0);
        expect_status("img1", 1'b1, 1'b0);

        // Empty image.
        pulse_reload();
        words_q.delete();
        build_image(0);
        run_image(2, 1'b0);
        tick(1'b0);
        expect_status("empty", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Empty image with a wrong checksum byte.
        pulse_reload();
        build_image(0);
        img_q[2] = 8'h01;
        run_image(0, 1'b0);
        tick(1'b0);
        expect_status("bad_chk", 1'b0, 1'b1);
`endif

        // Header count of MAX_WORDS+1 is rejected straight after the second byte.
        do_reset();
        img_q = '{8'h41, 8'h00};
        run_image(0, 1'b0);
        expect_status("too_long", 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick(1'b0);
        end
        rx_valid = 1'b0;
        pulse_reload();
        expect_status("err_sticky", 1'b0, 1'b1);

        // Exactly MAX_WORDS words with random gaps.
        do_reset();
        words_q.delete();
        for (int i = 0; i < MAX_W; i++) words_q.push_back($urandom);
        build_image(MAX_W);
        run_image(1, 1'b1);
        tick(1'b0);
        expect_status("max_words", 1'b1, 1'b0);

        // Directed two-word image with random 0-5 cycle gaps.
        for (int r = 0; r < 3; r++) begin
            pulse_reload();
            words_q = '{32'h12345678, 32'hDEADBEEF};
            build_image(2);
            run_image(5, 1'b1);
            tick(1'b0);
            expect_status("gaps", 1'b1, 1'b0);
        end

        // Random images.
        for (int r = 0; r < 6; r++) begin
            int n;
            pulse_reload();
            n = $urandom_range(5, 1);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            build_image(n);
            run_image(3, 1'b1);
            tick(1'b0);
            expect_status("rand", 1'b1, 1'b0);
        end

        // Reset after two payload bytes; stale lanes must not leak into the next image.
        pulse_reload();
        img_q = '{8'h02, 8'h00, 8'h99, 8'h88};
        run_image(0, 1'b0);
        do_reset();
        chk32("midrst_adr", Ext_DataAdr, BASE);
        expect_status("midrst", 1'b0, 1'b0);
        words_q = '{32'h44332211};
        build_image(1);
        run_image(0, 1'b0);
        tick(1'b0);
        expect_status("after_midrst", 1'b1, 1'b0);

        // Reset arriving with the word-completing byte cancels that write.
        pulse_reload();
        img_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        run_image(0, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        reset    = 1'b1;
        tick(1'b0);
        rx_valid = 1'b0;
        tick(1'b0);
        reset = 1'b0;
        chk32("cancel_wdata", Ext_WriteData, 32'd0);
        chk32("cancel_adr", Ext_DataAdr, BASE);
        expect_status("cancel", 1'b0, 1'b0);
        words_q = '{32'($urandom)};
        build_image(1);
        run_image(2, 1'b0);
        tick(1'b0);
        expect_status("after_cancel", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
